// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and leading-zero mask helper for the 7-segment scanner.
package seg7_pkg;

  localparam int unsigned NDIG = 4;
  localparam int unsigned NIB  = 4;
  localparam int unsigned DW   = NDIG * NIB;
  localparam int unsigned IW   = $clog2(NDIG);

  localparam logic [NDIG-1:0] DIG_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Bit k set when digit k and every digit to its left are zero; digit 0 always shown.
  function automatic logic [NDIG-1:0] lz_mask(input logic [DW-1:0] disp);
    logic [NDIG-1:0] m;
    logic            nz;
    m  = '0;
    nz = 1'b0;
    for (int k = NDIG - 1; k > 0; k--) begin
      nz   = nz | (disp[k*NIB +: NIB] != '0);
      m[k] = ~nz;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7scan_tick.sv
// Slot counter: counts 0..DIV-1 and emits registered pulses aligned with the counter value.
module seg7scan_tick #(
  parameter int unsigned DIV   = 48000,
  parameter int unsigned BLANK = 480
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start,
  output logic show_start,
  output logic slot_end,
  output logic show_arm
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (cnt == CW'(DIV - 1)) cnt_nxt = '0;
  end

  // Pulses are computed from the next count so each is high while cnt holds its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      slot_start <= 1'b1;
      show_start <= 1'b0;
      slot_end   <= 1'b0;
      show_arm   <= (BLANK == 1);
    end else begin
      cnt        <= cnt_nxt;
      slot_start <= (cnt_nxt == '0);
      show_start <= (cnt_nxt == CW'(BLANK));
      slot_end   <= (cnt_nxt == CW'(DIV - 1));
      show_arm   <= (cnt_nxt == CW'(BLANK - 1));
    end
  end

endmodule

// File: rtl/seg7scan.sv
// 4-digit multiplexed 7-segment scanner: shadow/display registers, slot FSM and digit enables.
module seg7scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIV   = 48000,
  parameter int unsigned BLANK = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   value,
  input  logic            load,
  input  logic            lzb,
  output logic [NIB-1:0]  digit,
  output logic [NDIG-1:0] dig_n,
  output logic            frame
);

  logic slot_start;
  logic show_start;
  logic slot_end;
  logic show_arm;

  seg7scan_tick #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .show_start (show_start),
    .slot_end   (slot_end),
    .show_arm   (show_arm)
  );

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   disp;
  logic [DW-1:0]   disp_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic            lzb_q;
  logic [NIB-1:0]  digit_nxt;
  logic [NDIG-1:0] dig_n_nxt;
  logic            frame_nxt;
  logic            frame_wrap;
  logic [NDIG-1:0] sup;

  assign frame_wrap = slot_end && (idx == IW'(NDIG - 1));
  assign sup        = lz_mask(disp);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_BLANK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: if (show_arm) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_end) state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  // Next values of the registered outputs and display datapath.
  always_comb begin
    disp_nxt  = disp;
    idx_nxt   = idx;
    digit_nxt = digit;
    dig_n_nxt = dig_n;
    frame_nxt = frame_wrap;
    if (frame_wrap) disp_nxt = load ? value : shadow;
    if (slot_end) begin
      idx_nxt   = idx + IW'(1);
      digit_nxt = disp_nxt[{idx_nxt, 2'b00} +: NIB];
    end
    // The enable pattern is decided once on entry to SHOW and held for the slot.
    if (state_nxt == ST_BLANK) begin
      dig_n_nxt = DIG_OFF;
    end else if (state == ST_BLANK) begin
      dig_n_nxt = (lzb_q && sup[idx]) ? DIG_OFF : ~(NDIG'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow <= '0;
      disp   <= '0;
      idx    <= '0;
      lzb_q  <= 1'b0;
      digit  <= '0;
      dig_n  <= DIG_OFF;
      frame  <= 1'b0;
    end else begin
      if (load)       shadow <= value;
      if (slot_start) lzb_q  <= lzb;
      disp  <= disp_nxt;
      idx   <= idx_nxt;
      digit <= digit_nxt;
      dig_n <= dig_n_nxt;
      frame <= frame_nxt;
    end
  end

  a_show_align: assert property (@(posedge clk) disable iff (!rst_n)
    show_start |-> (state == ST_SHOW));

endmodule

// File: tb/tb_seg7scan.sv
// Scoreboard bench for seg7scan at DIV=8, BLANK=2: per-slot expectations queued, then checked.
module tb_seg7scan;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        lzb;
  logic [3:0]  digit;
  logic [3:0]  dig_n;
  logic        frame;

  seg7scan #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .lzb   (lzb),
    .digit (digit),
    .dig_n (dig_n),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] digit;
    logic [3:0] dign;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // At most one enable low in any cycle.
  always @(negedge clk) begin
    if (mon_en) chk("onehot", 16'($countones(~dig_n) <= 1), 16'd1);
  end

  // Queue the four slots a frame showing v should produce.
  task automatic push_frame(input logic [15:0] v, input logic lz, input logic first);
    exp_t       e;
    logic [3:0] one;
    logic       s;
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      s       = lz && (k > 0) && ((v >> (4 * k)) == 16'h0000);
      e.digit = v[4*k +: 4];
      e.dign  = s ? 4'b1111 : ~(one << k);
      e.frame = (k == 0) && !first;
      sb.push_back(e);
    end
  endtask

  // Entered just after the edge that starts a slot; leaves just after the edge ending cycle ncyc-1.
  task automatic obs_slot(input int slot, input int ncyc, input int lcyc, input logic [15:0] lval);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c < ncyc; c++) begin
      load = (c == lcyc);
      if (c == lcyc) value = lval;
      @(negedge clk);
      if (c == 0) begin
        chk($sformatf("s%0d_digit_blank", slot), 16'(digit), 16'(e.digit));
        chk($sformatf("s%0d_dign_blank", slot), 16'(dig_n), 16'hF);
        chk($sformatf("s%0d_frame", slot), 16'(frame), 16'(e.frame));
      end
      if (c == 1) chk($sformatf("s%0d_frame_end", slot), 16'(frame), 16'd0);
      if (c == BLANK) begin
        chk($sformatf("s%0d_digit_show", slot), 16'(digit), 16'(e.digit));
        chk($sformatf("s%0d_dign_show", slot), 16'(dig_n), 16'(e.dign));
      end
      if (c == DIV - 1) chk($sformatf("s%0d_dign_last", slot), 16'(dig_n), 16'(e.dign));
      @(posedge clk);
      #1;
    end
    load = 1'b0;
  endtask

  task automatic run_frame(input int lslot, input int lcyc, input logic [15:0] lval);
    for (int s = 0; s < 4; s++) obs_slot(s, DIV, (s == lslot) ? lcyc : -1, lval);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t drop;
    rst_n = 1'b0;
    load  = 1'b0;
    value = 16'h0000;
    lzb   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_digit", 16'(digit), 16'h0);
    chk("rst_dign", 16'(dig_n), 16'hF);
    chk("rst_frame", 16'(frame), 16'h0);
    mon_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Blank display after reset; 1234 loaded at slot 0 becomes visible after the wrap.
    push_frame(16'h0000, 1'b0, 1'b1);
    run_frame(0, 0, 16'h1234);
    push_frame(16'h1234, 1'b0, 1'b0);
    run_frame(1, 3, 16'h0050);

    // Leading-zero blanking on, then off.
    lzb = 1'b1;
    push_frame(16'h0050, 1'b1, 1'b0);
    run_frame(-1, 0, 16'h0000);
    lzb = 1'b0;
    push_frame(16'h0050, 1'b0, 1'b0);
    run_frame(1, 3, 16'hABCD);

    // Load on the exact wrap cycle bypasses the shadow.
    push_frame(16'hABCD, 1'b0, 1'b0);
    run_frame(3, DIV - 1, 16'hFFFF);

    // Reset during slot 2 SHOW.
    push_frame(16'hFFFF, 1'b0, 1'b0);
    obs_slot(0, DIV, -1, 16'h0000);
    obs_slot(1, DIV, -1, 16'h0000);
    obs_slot(2, 4, -1, 16'h0000);
    drop  = sb.pop_front();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(16'h0000, 1'b0, 1'b1);
    run_frame(-1, 0, 16'h0000);
    push_frame(16'h0000, 1'b0, 1'b0);
    run_frame(-1, 0, 16'h0000);

    chk("sb_drained", 16'(sb.size()), 16'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
